// File: rtl/sync_fifo_pkg.sv
// Shared FIFO constants: default geometry, almost-flag levels and a
// ceiling-log2 helper used to size the pointers.
package sync_fifo_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int AF_LEVEL_DEF = 14;
  localparam int AE_LEVEL_DEF = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int ADDR_W_DEF = clog2(DEPTH_DEF);

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// The array and the read register carry no reset.
module sync_dp_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: free-running wrap-around pointers into sync_dp_ram,
// occupancy counter, decoded level flags and sticky error flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_acc_s, rd_acc_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == {(ADDR_W + 1){1'b0}});
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

  assign wr_acc_s = wr_en & (~full | rd_en);
  assign rd_acc_s = rd_en & ~empty;

  // Next-state for pointers, occupancy, read-valid and sticky errors.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc_s;
    rd_seen_d   = rd_seen_q | rd_acc_s;
    overflow_d  = overflow_q | (wr_en & full & ~rd_en);
    underflow_d = underflow_q | (rd_en & empty);
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously; queued data is abandoned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W + 1){1'b0}};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  sync_dp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc_s),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  // The RAM read register has no reset, so dout is forced to zero until the
  // first read after reset has loaded it.
  assign dout      = ram_rdata_s & {DATA_W{rd_seen_q}};
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized bench for sync_fifo against a queue-based model.
module tb_sync_fifo;

  logic       clk;
  logic       rstn;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int         total = 0;
  int         bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;

  sync_fifo dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    chk({ctx, "/count"},        32'(count),        32'(n));
    chk({ctx, "/full"},         32'(full),         32'(n == 16));
    chk({ctx, "/empty"},        32'(empty),        32'(n == 0));
    chk({ctx, "/almost_full"},  32'(almost_full),  32'(n >= 14));
    chk({ctx, "/almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    chk({ctx, "/dout"},         32'(dout),         32'(m_dout));
    chk({ctx, "/rd_valid"},     32'(rd_valid),     32'(m_valid));
    chk({ctx, "/overflow"},     32'(overflow),     32'(m_ovf));
    chk({ctx, "/underflow"},    32'(underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock with the given requests, then model update and full check.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string ctx);
    int n;
    bit wa, ra;
    n = q.size();
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wa = w && (n < 16 || r);
    ra = r && (n > 0);
    if (w && n == 16 && !r) m_ovf = 1'b1;
    if (r && n == 0) m_unf = 1'b1;
    m_valid = ra;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    check_all(ctx);
  endtask

  initial begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    rstn  = 1'b0;
    model_reset();
    #9;
    check_all("reset");
    #1;
    rstn = 1'b1;
    @(negedge clk);

    // Basic ordering.
    cyc(1'b1, 8'h11, 1'b0, "basic_wr");
    cyc(1'b1, 8'h22, 1'b0, "basic_wr");
    cyc(1'b1, 8'h33, 1'b0, "basic_wr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, "basic_rd");
    cyc(1'b0, 8'h00, 1'b0, "basic_idle");

    // Fill to full, overflow attempt, drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, "fill");
    cyc(1'b1, 8'hAA, 1'b0, "overflow");
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, "drain");

    // Underflow from empty.
    cyc(1'b0, 8'h00, 1'b1, "underflow");

    // Simultaneous read/write while full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, "fill2");
    cyc(1'b1, 8'h55, 1'b1, "simul_full");
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, "drain2");

    // Simultaneous read/write while empty: write only.
    cyc(1'b1, 8'h77, 1'b1, "simul_empty");
    cyc(1'b0, 8'h00, 1'b1, "simul_empty_rd");

    // Mixed random traffic across several pointer wraps.
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1 & ($urandom_range(0, 99) < 70), 8'($urandom), 1'b1 & ($urandom_range(0, 99) < 60), "random");
    end

    // Settle at five entries, then reset asynchronously between edges.
    while (q.size() > 5) cyc(1'b0, 8'h00, 1'b1, "trim");
    while (q.size() < 5) cyc(1'b1, 8'($urandom), 1'b0, "topup");
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check_all("after_reset");
    cyc(1'b1, 8'h99, 1'b0, "post_reset_wr");
    cyc(1'b0, 8'h00, 1'b1, "post_reset_rd");
    cyc(1'b0, 8'h00, 1'b0, "post_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
